// File: rtl/copro_s_axi_regs_if.sv
// AXI4-Lite bus bundle between the interconnect initiator and the coprocessor register file.
// The master modport is the initiator side; the slave modport is the responder side.
interface copro_s_axi_regs_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/copro_s_axi_regs.sv
// AXI4-Lite responder holding the coprocessor register file; exposes every register
// and a one-cycle write pulse per register to the datapath.
module copro_s_axi_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int C_NUM_REGS         = 4
) (
    input  logic                                       s_axi_aclk,
    input  logic                                       s_axi_aresetn,
    copro_s_axi_regs_if.slave                          s_axi,
    output logic [C_S_AXI_DATA_WIDTH*C_NUM_REGS-1:0]   reg_q,
    output logic [C_NUM_REGS-1:0]                      reg_wr_pulse
);
    localparam int DW    = C_S_AXI_DATA_WIDTH;
    localparam int AW    = C_S_AXI_ADDR_WIDTH;
    localparam int IDX_W = AW - 2;
    localparam int NB    = DW / 8;

    typedef enum logic { W_IDLE, W_RESP } wstate_e;
    typedef enum logic { R_IDLE, R_DATA } rstate_e;

    wstate_e              wstate_q;
    rstate_e              rstate_q;
    logic                 awready_q, wready_q, bvalid_q;
    logic                 arready_q, rvalid_q;
    logic [DW-1:0]        rdata_q;
    logic                 aw_done_q, w_done_q;
    logic [IDX_W-1:0]     awidx_q;
    logic [DW-1:0]        wdata_q;
    logic [NB-1:0]        wstrb_q;
    logic [C_NUM_REGS-1:0] wr_pulse_q;
    logic [DW-1:0]        regs_q [C_NUM_REGS];
    logic [DW-1:0]        reg_d  [C_NUM_REGS];

    logic                 aw_hs, w_hs, ar_hs;
    logic                 aw_have, w_have, wr_commit;
    logic [IDX_W-1:0]     wr_idx, rd_idx;
    logic [DW-1:0]        wr_data;
    logic [NB-1:0]        wr_strb;
    logic [C_NUM_REGS-1:0] wr_sel;

    // Readies are only ever high in the idle states, so they double as state qualifiers.
    assign aw_hs     = s_axi.awvalid & awready_q;
    assign w_hs      = s_axi.wvalid  & wready_q;
    assign ar_hs     = s_axi.arvalid & arready_q;
    assign aw_have   = aw_done_q | aw_hs;
    assign w_have    = w_done_q  | w_hs;
    assign wr_commit = (wstate_q == W_IDLE) & aw_have & w_have;

    // Whichever half arrives on the commit edge is taken straight from the bus.
    assign wr_idx  = aw_done_q ? awidx_q : s_axi.awaddr[AW-1:2];
    assign wr_data = w_done_q  ? wdata_q : s_axi.wdata;
    assign wr_strb = w_done_q  ? wstrb_q : s_axi.wstrb;
    assign rd_idx  = s_axi.araddr[AW-1:2];

    genvar gi, bi;
    generate
        for (gi = 0; gi < C_NUM_REGS; gi++) begin : g_reg
            for (bi = 0; bi < NB; bi++) begin : g_byte
                assign reg_d[gi][8*bi +: 8] = wr_strb[bi] ? wr_data[8*bi +: 8]
                                                          : regs_q[gi][8*bi +: 8];
            end

            assign wr_sel[gi] = wr_commit & (wr_idx == IDX_W'(gi));

            always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
                if (!s_axi_aresetn) begin
                    regs_q[gi] <= '0;
                end else if (wr_sel[gi]) begin
                    regs_q[gi] <= reg_d[gi];
                end
            end

            assign reg_q[DW*gi +: DW] = regs_q[gi];
        end
    endgenerate

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            wstate_q   <= W_IDLE;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            awidx_q    <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            wr_pulse_q <= '0;
        end else begin
            wr_pulse_q <= wr_sel;
            case (wstate_q)
                W_IDLE: begin
                    if (wr_commit) begin
                        wstate_q  <= W_RESP;
                        bvalid_q  <= 1'b1;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b0;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                    end else begin
                        aw_done_q <= aw_have;
                        w_done_q  <= w_have;
                        awready_q <= ~aw_have;
                        wready_q  <= ~w_have;
                        if (aw_hs) awidx_q <= s_axi.awaddr[AW-1:2];
                        if (w_hs) begin
                            wdata_q <= s_axi.wdata;
                            wstrb_q <= s_axi.wstrb;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi.bready) begin
                        wstate_q  <= W_IDLE;
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                    end
                end
                default: wstate_q <= W_IDLE;
            endcase
        end
    end

    // A read accepted on a commit edge samples regs_q before the update lands.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            rstate_q  <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            case (rstate_q)
                R_IDLE: begin
                    if (ar_hs) begin
                        rstate_q  <= R_DATA;
                        rdata_q   <= regs_q[rd_idx];
                        rvalid_q  <= 1'b1;
                        arready_q <= 1'b0;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (s_axi.rready) begin
                        rstate_q  <= R_IDLE;
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                    end
                end
                default: rstate_q <= R_IDLE;
            endcase
        end
    end

    assign s_axi.awready = awready_q;
    assign s_axi.wready  = wready_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = 2'b00;
    assign s_axi.arready = arready_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = 2'b00;
    assign reg_wr_pulse  = wr_pulse_q;

    // Protection bits and byte-lane address bits carry no meaning here.
    logic unused_ok;
    assign unused_ok = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0]};
endmodule

// File: tb/tb_copro_s_axi_regs.sv
// Scoreboarded bench for copro_s_axi_regs: stimulus pushes expected B/R responses,
// a negedge monitor pops and compares them; directed checks cover timing and reset.
module tb_copro_s_axi_regs;
    logic         clk;
    logic         rst_n;
    logic [127:0] reg_q;
    logic [3:0]   reg_wr_pulse;

    int vectors     = 0;
    int miscompares = 0;

    logic [1:0]  exp_b [$];
    logic [33:0] exp_r [$];
    logic [1:0]  want_b;
    logic [33:0] want_r;

    copro_s_axi_regs_if #(.ADDR_W(4), .DATA_W(32)) bus ();

    copro_s_axi_regs #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(4),
        .C_NUM_REGS(4)
    ) dut (
        .s_axi_aclk   (clk),
        .s_axi_aresetn(rst_n),
        .s_axi        (bus),
        .reg_q        (reg_q),
        .reg_wr_pulse (reg_wr_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, want);
        end
    endtask

    // Scoreboard monitor: compares every completed B and R handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.bvalid && bus.bready) begin
                if (exp_b.size() == 0) begin
                    chk("b_unexpected", 1, 0);
                end else begin
                    want_b = exp_b.pop_front();
                    $display("B  bresp=%0h", bus.bresp);
                    chk("bresp", bus.bresp, want_b);
                end
            end
            if (bus.rvalid && bus.rready) begin
                if (exp_r.size() == 0) begin
                    chk("r_unexpected", 1, 0);
                end else begin
                    want_r = exp_r.pop_front();
                    $display("R  rresp=%0h rdata=%08h", bus.rresp, bus.rdata);
                    chk("rresp_rdata", {bus.rresp, bus.rdata}, want_r);
                end
            end
        end
    end

    task automatic send_aw_w(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        logic awf, wf;
        exp_b.push_back(2'b00);
        bus.awaddr = a; bus.awvalid = 1'b1;
        bus.wdata  = d; bus.wstrb   = s; bus.wvalid = 1'b1;
        for (int c = 0; c < 100 && (bus.awvalid || bus.wvalid); c++) begin
            @(negedge clk);
            awf = bus.awvalid && bus.awready;
            wf  = bus.wvalid && bus.wready;
            @(posedge clk); #1;
            if (awf) bus.awvalid = 1'b0;
            if (wf)  bus.wvalid  = 1'b0;
        end
        chk("aw_w_timeout", {bus.awvalid, bus.wvalid}, 0);
    endtask

    task automatic wait_b();
        bit got = 0;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            got = bus.bvalid && bus.bready;
            @(posedge clk); #1;
        end
        chk("b_timeout", got, 1);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        send_aw_w(a, d, s);
        wait_b();
    endtask

    task automatic send_ar(input logic [3:0] a);
        logic arf;
        bus.araddr = a; bus.arvalid = 1'b1;
        for (int c = 0; c < 100 && bus.arvalid; c++) begin
            @(negedge clk);
            arf = bus.arvalid && bus.arready;
            @(posedge clk); #1;
            if (arf) bus.arvalid = 1'b0;
        end
        chk("ar_timeout", bus.arvalid, 0);
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] want);
        bit got = 0;
        exp_r.push_back({2'b00, want});
        send_ar(a);
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            got = bus.rvalid && bus.rready;
            @(posedge clk); #1;
        end
        chk("r_timeout", got, 1);
    endtask

    task automatic chk_reset_state(input string nm);
        chk({nm, "_ctl"}, {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid,
                           bus.bresp, bus.rresp}, 0);
        chk({nm, "_rdata"}, bus.rdata, 0);
        chk({nm, "_regs"}, reg_q, 0);
        chk({nm, "_pulse"}, reg_wr_pulse, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic awf;
        rst_n = 1'b0;
        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata  = '0; bus.wstrb  = '0; bus.wvalid  = 1'b0;
        bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0;
        bus.bready = 1'b1; bus.rready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk_reset_state("reset");
        @(negedge clk); rst_n = 1'b1;
        #1 chk("ready_before_edge", {bus.awready, bus.wready, bus.arready}, 3'b000);
        @(posedge clk); #1;
        chk("ready_after_edge", {bus.awready, bus.wready, bus.arready}, 3'b111);

        // 1: full-word writes with readback
        wr(4'h0, 32'h0101FFFF, 4'hF); rd(4'h0, 32'h0101FFFF);
        wr(4'h4, 32'hABCD0001, 4'hF); rd(4'h4, 32'hABCD0001);
        wr(4'h8, 32'hDEAD0011, 4'hF); rd(4'h8, 32'hDEAD0011);
        wr(4'hC, 32'hBEEF0011, 4'hF); rd(4'hC, 32'hBEEF0011);
        chk("t1_reg_q", reg_q, 128'hBEEF0011_DEAD0011_ABCD0001_0101FFFF);

        // 2: AW three cycles ahead of W
        exp_b.push_back(2'b00);
        bus.awaddr = 4'h4; bus.awvalid = 1'b1;
        bus.wdata = 32'h11223344; bus.wstrb = 4'hF;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            awf = bus.awvalid && bus.awready;
            chk("t2_bvalid_early", bus.bvalid, 0);
            chk("t2_pulse_early", reg_wr_pulse, 0);
            @(posedge clk); #1;
            if (awf) bus.awvalid = 1'b0;
        end
        chk("t2_aw_taken", bus.awvalid, 0);
        bus.wvalid = 1'b1;
        @(negedge clk);
        chk("t2_wready", bus.wready, 1);
        chk("t2_bvalid_at_w", bus.bvalid, 0);
        @(posedge clk); #1;
        bus.wvalid = 1'b0;
        chk("t2_bvalid_rise", bus.bvalid, 1);
        chk("t2_pulse", reg_wr_pulse, 4'b0010);
        @(posedge clk); #1;
        chk("t2_pulse_once", reg_wr_pulse, 0);
        chk("t2_bvalid_fall", bus.bvalid, 0);
        rd(4'h4, 32'h11223344);

        // 3: byte-strobe merge
        wr(4'h8, 32'hFFFFFFFF, 4'hF);
        wr(4'h8, 32'h12345678, 4'b0101);
        rd(4'h8, 32'hFF34FF78);

        // 4: B back-pressure blocks the next write
        bus.bready = 1'b0;
        send_aw_w(4'h4, 32'hC0FFEE04, 4'hF);
        bus.awaddr = 4'h4; bus.awvalid = 1'b1;
        bus.wdata = 32'h600DF00D; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("t4_hold", {bus.bvalid, bus.awready, bus.wready}, 3'b100);
            chk("t4_reg1", reg_q[63:32], 32'hC0FFEE04);
            @(posedge clk); #1;
        end
        bus.bready = 1'b1;
        wr(4'h4, 32'h600DF00D, 4'hF);
        rd(4'h4, 32'h600DF00D);

        // 5: read accepted on the commit edge sees the old value
        wr(4'h0, 32'hA5A5A5A5, 4'hF);
        fork
            begin
                send_aw_w(4'h0, 32'h5A5A5A5A, 4'hF);
                wait_b();
            end
            rd(4'h0, 32'hA5A5A5A5);
        join
        chk("t5_reg0", reg_q[31:0], 32'h5A5A5A5A);
        rd(4'h0, 32'h5A5A5A5A);

        // 6: reset with both responses pending
        bus.bready = 1'b0; bus.rready = 1'b0;
        send_aw_w(4'hC, 32'h00001234, 4'hF);
        send_ar(4'h0);
        @(negedge clk);
        chk("t6_pending", {bus.bvalid, bus.rvalid}, 2'b11);
        rst_n = 1'b0;
        #1;
        chk_reset_state("t6_reset");
        exp_b.delete();
        exp_r.delete();
        @(posedge clk); #1;
        chk("t6_regs_held", reg_q, 0);
        @(negedge clk);
        rst_n = 1'b1; bus.bready = 1'b1; bus.rready = 1'b1;
        @(posedge clk); #1;
        chk("t6_ready", {bus.awready, bus.wready, bus.arready}, 3'b111);
        wr(4'hC, 32'hBEEF0011, 4'hF);
        rd(4'hC, 32'hBEEF0011);

        repeat (2) @(posedge clk);
        chk("exp_b_drained", exp_b.size(), 0);
        chk("exp_r_drained", exp_r.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
